// File: rtl/aclk_controller.sv
// Alarm-clock control FSM: keypad entry, alarm display, alarm/time load strobes; idle timeout under ACLK_ENTRY_TIMEOUT_EN.
// Latency: outputs are combinational from the current state and inputs; state advances on each rising clock edge.
// Backpressure: none; strobes are single-cycle pulses and downstream registers must accept them when they occur.
module aclk_controller #(
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] NOKEY       = 4'd10
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_one_second,
    input  logic       i_alarm_button,
    input  logic       i_time_button,
    input  logic [3:0] i_key,
    output logic       o_show_new_time,
    output logic       o_show_a,
    output logic       o_shift,
    output logic       o_load_new_a,
    output logic       o_load_new_c
);

    localparam logic [2:0] S_SHOW_TIME  = 3'd0;
    localparam logic [2:0] S_KEY_STORED = 3'd1;
    localparam logic [2:0] S_KEY_WAITED = 3'd2;
    localparam logic [2:0] S_KEY_ENTRY  = 3'd3;
    localparam logic [2:0] S_SHOW_ALARM = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       w_key_pressed;
    logic       w_timeout;

    assign w_key_pressed = (i_key != NOKEY);

`ifdef ACLK_ENTRY_TIMEOUT_EN
    localparam logic [3:0] LP_LAST_COUNT = 4'(TIMEOUT_SEC - 1);

    logic [3:0] r_count;
    logic       w_counting;

    assign w_counting = (r_state == S_KEY_WAITED) || (r_state == S_KEY_ENTRY);
    assign w_timeout  = w_counting && i_one_second && (r_count == LP_LAST_COUNT);

    // Saturates at the last count; the FSM leaves the counting states on the next tick anyway.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= 4'd0;
        end else if (!w_counting) begin
            r_count <= 4'd0;
        end else if (i_one_second && (r_count != LP_LAST_COUNT)) begin
            r_count <= r_count + 4'd1;
        end
    end
`else
    logic w_unused_one_second;

    assign w_unused_one_second = i_one_second;
    assign w_timeout           = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_SHOW_TIME: begin
                if (i_alarm_button)     w_next_state = S_SHOW_ALARM;
                else if (w_key_pressed) w_next_state = S_KEY_STORED;
            end
            S_SHOW_ALARM: begin
                if (!i_alarm_button)    w_next_state = S_SHOW_TIME;
            end
            S_KEY_STORED: begin
                w_next_state = S_KEY_WAITED;
            end
            S_KEY_WAITED: begin
                if (!w_key_pressed)     w_next_state = S_KEY_ENTRY;
                else if (w_timeout)     w_next_state = S_SHOW_TIME;
            end
            S_KEY_ENTRY: begin
                if (i_alarm_button)     w_next_state = S_SHOW_TIME;
                else if (i_time_button) w_next_state = S_SHOW_TIME;
                else if (w_key_pressed) w_next_state = S_KEY_STORED;
                else if (w_timeout)     w_next_state = S_SHOW_TIME;
            end
            default: begin
                w_next_state = S_SHOW_TIME;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_SHOW_TIME;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Reset masks every output so a reset arriving mid-entry cannot fire a load strobe.
    always_comb begin
        o_show_new_time = 1'b0;
        o_show_a        = 1'b0;
        o_shift         = 1'b0;
        o_load_new_a    = 1'b0;
        o_load_new_c    = 1'b0;
        if (!i_reset) begin
            o_show_new_time = (r_state == S_KEY_STORED) || (r_state == S_KEY_WAITED) ||
                              (r_state == S_KEY_ENTRY);
            o_show_a        = (r_state == S_SHOW_ALARM);
            o_shift         = (r_state == S_KEY_STORED);
            o_load_new_a    = (r_state == S_KEY_ENTRY) && i_alarm_button;
            o_load_new_c    = (r_state == S_KEY_ENTRY) && i_time_button && !i_alarm_button;
        end
    end

endmodule

// File: tb/tb_aclk_controller.sv
// Directed bench for aclk_controller: each step drives one cycle of inputs, queues the expected outputs, and checks them mid-cycle.
module tb_aclk_controller;

    localparam logic [3:0] NK = 4'd10;

    logic       clock;
    logic       reset;
    logic       one_second;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] key;
    logic       show_new_time;
    logic       show_a;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    aclk_controller #(.TIMEOUT_SEC(10), .NOKEY(NK)) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_one_second    (one_second),
        .i_alarm_button  (alarm_button),
        .i_time_button   (time_button),
        .i_key           (key),
        .o_show_new_time (show_new_time),
        .o_show_a        (show_a),
        .o_shift         (shift),
        .o_load_new_a    (load_new_a),
        .o_load_new_c    (load_new_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output vector order: {show_new_time, show_a, shift, load_new_a, load_new_c}
    task automatic step(input logic r, input logic a, input logic t, input logic [3:0] k,
                        input logic tick, input logic [4:0] exp, input string tag);
        logic [4:0] obs;
        logic [4:0] want;
        string      name;
        reset        = r;
        alarm_button = a;
        time_button  = t;
        key          = k;
        one_second   = tick;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #3;
        obs  = {show_new_time, show_a, shift, load_new_a, load_new_c};
        want = exp_q.pop_front();
        name = tag_q.pop_front();
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", name, obs, want);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        alarm_button = 1'b1;
        time_button  = 1'b0;
        key          = 4'd5;
        one_second   = 1'b0;
        @(posedge clock);
        #1;

        // Reset dominates a held key and alarm button.
        step(1, 1, 0, 4'd5, 0, 5'b00000, "reset_cycle1");
        step(1, 1, 0, 4'd5, 0, 5'b00000, "reset_cycle2");
        step(0, 0, 0, NK,   0, 5'b00000, "post_reset_idle");

        // Held key: one shift, then wait for release.
        step(0, 0, 0, 4'd3, 0, 5'b00000, "key3_press_show_time");
        step(0, 0, 0, 4'd3, 0, 5'b10100, "key3_stored_shift");
        step(0, 0, 0, 4'd3, 0, 5'b10000, "key3_held_no_shift1");
        step(0, 0, 0, 4'd3, 0, 5'b10000, "key3_held_no_shift2");
        step(0, 0, 0, NK,   0, 5'b10000, "key3_release");
        step(0, 0, 0, NK,   0, 5'b10000, "entry_idle");

        // Time button held 3 cycles: a single load_new_c.
        step(0, 0, 1, NK,   0, 5'b10001, "time_load_c");
        step(0, 0, 1, NK,   0, 5'b00000, "time_held_no_reload1");
        step(0, 0, 1, NK,   0, 5'b00000, "time_held_no_reload2");
        step(0, 0, 0, NK,   0, 5'b00000, "time_released");

        // Non-digit code counts as a key; then alarm+time together.
        step(0, 0, 0, 4'd15, 0, 5'b00000, "key15_press");
        step(0, 0, 0, NK,    0, 5'b10100, "key15_stored_shift");
        step(0, 0, 0, NK,    0, 5'b10000, "key15_waited");
        step(0, 0, 0, NK,    0, 5'b10000, "key15_entry");
        step(0, 1, 1, NK,    0, 5'b10010, "both_buttons_load_a_only");
        step(0, 1, 1, NK,    0, 5'b00000, "both_held_show_time");
        step(0, 1, 0, NK,    0, 5'b01000, "show_alarm");
        step(0, 1, 0, 4'd4,  0, 5'b01000, "show_alarm_key_ignored");
        step(0, 0, 0, NK,    0, 5'b01000, "alarm_release");
        step(0, 0, 0, NK,    0, 5'b00000, "back_to_show_time");

        // Reset mid-entry suppresses the load strobe.
        step(0, 0, 0, 4'd1, 0, 5'b00000, "key1_press");
        step(0, 0, 0, NK,   0, 5'b10100, "key1_stored");
        step(0, 0, 0, NK,   0, 5'b10000, "key1_waited");
        step(1, 0, 1, NK,   0, 5'b00000, "reset_mid_entry_no_load");
        step(0, 0, 1, NK,   0, 5'b00000, "after_mid_reset_show_time");
        step(0, 0, 0, NK,   0, 5'b00000, "after_mid_reset_idle");

        // Enter KEY_ENTRY for the timeout scenarios.
        step(0, 0, 0, 4'd2, 0, 5'b00000, "key2_press");
        step(0, 0, 0, NK,   0, 5'b10100, "key2_stored");
        step(0, 0, 0, NK,   0, 5'b10000, "key2_waited");
`ifdef ACLK_ENTRY_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, NK, 1, 5'b10000, $sformatf("tick%0d", i));
            step(0, 0, 0, NK, 0, 5'b10000, $sformatf("gap%0d", i));
        end
        step(0, 0, 0, 4'd6, 1, 5'b10000, "tick9_with_key");
        step(0, 0, 0, 4'd6, 0, 5'b10100, "key6_stored");
        step(0, 0, 0, NK,   0, 5'b10000, "key6_waited");
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0, NK, 1, 5'b10000, $sformatf("retick%0d", i));
            step(0, 0, 0, NK, 0, 5'b10000, $sformatf("regap%0d", i));
        end
        step(0, 0, 0, NK, 1, 5'b10000, "retick10");
        step(0, 0, 0, NK, 0, 5'b00000, "timeout_show_time");
        step(0, 0, 1, NK, 0, 5'b00000, "timeout_no_load");
`else
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, 0, NK, 1, 5'b10000, $sformatf("notimeout_tick%0d", i));
            step(0, 0, 0, NK, 0, 5'b10000, $sformatf("notimeout_gap%0d", i));
        end
        step(0, 0, 1, NK, 0, 5'b10001, "late_time_load_c");
        step(0, 0, 0, NK, 0, 5'b00000, "late_show_time");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aclk_controller.md
Name: aclk_controller

Overview:
- Main control FSM of the alarm clock. Sits directly upstream of the LCD driver and feeds its show_a / show_new_time select inputs.
- Decodes keypad digits and the alarm/time buttons. Issues shift strobes to the key register and load strobes to the alarm and current-time registers.
- Returns to normal time display after a programmable idle timeout measured in one_second ticks.

Parameters:
- TIMEOUT_SEC, 10: number of one_second ticks without a new key before key entry is abandoned. Legal range 1..15.
- NOKEY, 4'd10: key code meaning "no key pressed". Keys 0..9 are digits; any other non-NOKEY code is treated as a digit press.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- one_second  input  1  one-cycle tick, once per second
- alarm_button  input  1  level, high while alarm button held
- time_button  input  1  level, high while time-set button held
- key  input  4  current keypad code, NOKEY when idle
- show_new_time  output  1  high while key-entry digits are displayed
- show_a  output  1  high while alarm time is displayed
- shift  output  1  one-cycle strobe: shift key into key register
- load_new_a  output  1  one-cycle strobe: load key register into alarm register
- load_new_c  output  1  one-cycle strobe: load key register into current-time counter

Behaviour:
- One clock domain. Reset is synchronous, active-high. Reset dominates every other input in the same cycle.
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM. State register encoding is free.
- Reset state is SHOW_TIME and the timeout counter is 0.
- Transitions are evaluated each clock; rows are listed in priority order.
- SHOW_TIME:
  - alarm_button=1 -> SHOW_ALARM.
  - else key!=NOKEY -> KEY_STORED.
  - else stay.
- SHOW_ALARM:
  - alarm_button=0 -> SHOW_TIME.
  - else stay. Keys are ignored.
- KEY_STORED: unconditionally -> KEY_WAITED. Lasts exactly 1 cycle.
- KEY_WAITED (waiting for key release):
  - key==NOKEY -> KEY_ENTRY.
  - else timeout -> SHOW_TIME.
  - else stay.
- KEY_ENTRY:
  - alarm_button=1 -> SHOW_TIME.
  - else time_button=1 -> SHOW_TIME.
  - else key!=NOKEY -> KEY_STORED.
  - else timeout -> SHOW_TIME.
  - else stay.
- Outputs are combinational from the current state and inputs. No registered output delay.
  - show_new_time=1 in KEY_STORED, KEY_WAITED and KEY_ENTRY; else 0.
  - show_a=1 in SHOW_ALARM only.
  - shift=1 in KEY_STORED only, so exactly one pulse per distinct key press. A held key produces no further shifts.
  - load_new_a = (state==KEY_ENTRY) & alarm_button.
  - load_new_c = (state==KEY_ENTRY) & time_button & ~alarm_button. Alarm has priority on a simultaneous press; only load_new_a pulses.
  - Each load strobe is exactly 1 cycle because the FSM leaves KEY_ENTRY on the next edge.
- All outputs read 0 in the cycle after reset is asserted, except that the state is then SHOW_TIME.
- Timeout counter:
  - Width 4 bits.
  - Cleared in SHOW_TIME, SHOW_ALARM and KEY_STORED.
  - Increments on one_second while in KEY_WAITED or KEY_ENTRY.
  - timeout = one_second & (count==TIMEOUT_SEC-1), evaluated in KEY_WAITED/KEY_ENTRY. The FSM therefore exits on the TIMEOUT_SEC-th tick after the last key press.
  - The counter does not increment past TIMEOUT_SEC-1 and never wraps.
- A one_second tick coinciding with a key press in KEY_ENTRY: the key wins (-> KEY_STORED) and the counter is cleared.
- Reset mid-entry: the FSM returns to SHOW_TIME, no load strobe is issued, and the key register contents are left to downstream.

Optional Feature:
- Macro ACLK_ENTRY_TIMEOUT_EN.
- Defined: timeout counter and timeout exits are implemented as described above.
- Undefined:
  - The counter is not instantiated and timeout is constant 0.
  - KEY_WAITED and KEY_ENTRY persist indefinitely until a button or key event.
  - one_second is unused.
  - All other behaviour is identical.

Test Plan:
- Reset held 2 cycles with key=5 and alarm_button=1 -> state SHOW_TIME; all outputs 0 during and after reset until inputs are re-evaluated.
- SHOW_TIME, key=3 held 4 cycles then NOKEY -> shift high exactly 1 cycle; show_new_time high from the cycle after the press; state reaches KEY_ENTRY after release.
- KEY_ENTRY, time_button=1 for 3 cycles -> load_new_c high exactly 1 cycle, load_new_a 0; show_new_time drops next cycle.
- KEY_ENTRY, alarm_button=1 and time_button=1 together -> load_new_a pulses once, load_new_c stays 0; then SHOW_ALARM is entered while alarm_button stays held.
- KEY_ENTRY idle, 10 one_second ticks (TIMEOUT_SEC=10) -> return to SHOW_TIME on the 10th tick edge with no loads. A key on tick 9 restarts the count, and 10 more ticks are required.
- Without ACLK_ENTRY_TIMEOUT_EN, KEY_ENTRY idle for 50 ticks -> show_new_time stays 1; time_button then yields one load_new_c pulse.
